frame_crop_ctrl: RTL

- Sequencing and configuration controller for the ISP boundary-crop datapath.
- Watches the same vs/hs/de timing stream that the crop datapath sees, measures active frame geometry, and locks once geometry is stable.
- Accepts skip-row/skip-col configuration over a valid/ready handshake and commits it only on frame boundaries.
- Drives the runtime crop window and enable of a run-time-programmable crop stage, so no crop change can tear a frame.

---
 rtl/frame_crop_ctrl_pkg.sv | 15 +
 rtl/frame_geom_meter.sv | 85 ++++++++
 rtl/frame_crop_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/frame_crop_ctrl_pkg.sv
// Shared definitions for the boundary-crop sequencing controller.
package frame_crop_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } crop_state_e;

    // Largest value a counter of the given width can hold; counters stick here.
    function automatic int unsigned sat_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/frame_geom_meter.sv
// Measures active width/height of each frame from the vs/de stream and
// reports them, with a consistency flag, on a pulse at every vs rising edge.
module frame_geom_meter
    import frame_crop_ctrl_pkg::*;
#(
    parameter int CNT_BITS = 12
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                vs_i,
    input  logic                de_i,
    output logic                frame_done_o,
    output logic [CNT_BITS-1:0] frame_w_o,
    output logic [CNT_BITS-1:0] frame_h_o,
    output logic                consistent_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(sat_max(CNT_BITS));

    logic                vs_q;
    logic                de_q;
    logic                vs_rise;
    logic                de_fall;
    logic                first_line;
    logic [CNT_BITS-1:0] col_cnt;
    logic [CNT_BITS-1:0] row_cnt;
    logic [CNT_BITS-1:0] ref_w;
    logic                mism;
    logic                sat;
    logic [CNT_BITS-1:0] row_nxt;
    logic [CNT_BITS-1:0] ref_nxt;
    logic                mism_nxt;
    logic                sat_nxt;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign vs_rise    = vs_i & ~vs_q;
    assign de_fall    = ~de_i & de_q;
    assign first_line = (row_cnt == '0);

    // Frame statistics including a line that ends in this very cycle, so a
    // de fall coinciding with vs rise still counts toward the closing frame.
    always_comb begin
        row_nxt  = de_fall ? sat_inc(row_cnt) : row_cnt;
        ref_nxt  = (de_fall && first_line) ? col_cnt : ref_w;
        mism_nxt = mism | (de_fall & ~first_line & (col_cnt != ref_w));
        sat_nxt  = sat | (de_i & (col_cnt == CNT_MAX)) | (de_fall & (row_cnt == CNT_MAX));
    end

    assign frame_done_o = vs_rise;
    assign frame_w_o    = ref_nxt;
    assign frame_h_o    = row_nxt;
    assign consistent_o = ~mism_nxt & (row_nxt != '0) & ~sat_nxt;

    // Edge-detect registers, saturating counters and per-frame flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
            col_cnt <= '0;
            row_cnt <= '0;
            ref_w   <= '0;
            mism    <= 1'b0;
            sat     <= 1'b0;
        end else begin
            vs_q    <= vs_i;
            de_q    <= de_i;
            col_cnt <= de_i ? sat_inc(col_cnt) : '0;
            if (vs_rise) begin
                row_cnt <= '0;
                ref_w   <= '0;
                mism    <= 1'b0;
                sat     <= 1'b0;
            end else begin
                row_cnt <= row_nxt;
                ref_w   <= ref_nxt;
                mism    <= mism_nxt;
                sat     <= sat_nxt;
            end
        end
    end

endmodule

// File: rtl/frame_crop_ctrl.sv
// Lock/measure FSM, frame-boundary config commit and crop-window arithmetic
// for the run-time programmable boundary-crop stage.
module frame_crop_ctrl
    import frame_crop_ctrl_pkg::*;
#(
    parameter int CNT_BITS      = 12,
    parameter int DEF_SKIP_ROWS = 10,
    parameter int DEF_SKIP_COLS = 10,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                vs_i,
    input  logic                hs_i,
    input  logic                de_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CNT_BITS-1:0] cfg_skip_rows_i,
    input  logic [CNT_BITS-1:0] cfg_skip_cols_i,
    output logic [CNT_BITS-1:0] col_lo_o,
    output logic [CNT_BITS-1:0] col_hi_o,
    output logic [CNT_BITS-1:0] row_lo_o,
    output logic [CNT_BITS-1:0] row_hi_o,
    output logic                crop_en_o,
    output logic                locked_o,
    output logic                cfg_err_o,
    output logic [CNT_BITS-1:0] frame_w_o,
    output logic [CNT_BITS-1:0] frame_h_o
);

    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_BITS-1:0] DEF_ROWS = CNT_BITS'(DEF_SKIP_ROWS);
    localparam logic [CNT_BITS-1:0] DEF_COLS = CNT_BITS'(DEF_SKIP_COLS);

    crop_state_e         state;
    logic [MW-1:0]       match_cnt;
    logic [MW-1:0]       match_nxt;
    logic [CNT_BITS-1:0] cand_w;
    logic [CNT_BITS-1:0] cand_h;
    logic [CNT_BITS-1:0] skip_rows;
    logic [CNT_BITS-1:0] skip_cols;
    logic [CNT_BITS-1:0] pend_rows;
    logic [CNT_BITS-1:0] pend_cols;
    logic [CNT_BITS-1:0] skip_rows_nxt;
    logic [CNT_BITS-1:0] skip_cols_nxt;
    logic                frame_done;
    logic                meas_cons;
    logic [CNT_BITS-1:0] meas_w;
    logic [CNT_BITS-1:0] meas_h;
    logic                cfg_accept;
    logic                cfg_pending;
    logic                stay_locked;
    logic                lock_hit;
    logic                load_bnd;
    logic [2*CNT_BITS:0] col_bnd;
    logic [2*CNT_BITS:0] row_bnd;
    logic                bnd_fit;
    logic                unused_hs;

    // One axis of the window: {fits, lo, hi}. Doubling the skip needs one
    // extra bit so a large skip cannot wrap into an apparently valid window.
    function automatic logic [2*CNT_BITS:0] axis_bounds(input logic [CNT_BITS-1:0] size,
                                                        input logic [CNT_BITS-1:0] skip);
        logic [CNT_BITS:0]   twice_skip;
        logic [CNT_BITS-1:0] hi;
        twice_skip = {skip, 1'b0};
        hi         = size - skip;
        if (twice_skip >= {1'b0, size}) begin
            return '0;
        end
        return {1'b1, skip, hi};
    endfunction

    frame_geom_meter #(
        .CNT_BITS (CNT_BITS)
    ) u_meter (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .vs_i         (vs_i),
        .de_i         (de_i),
        .frame_done_o (frame_done),
        .frame_w_o    (meas_w),
        .frame_h_o    (meas_h),
        .consistent_o (meas_cons)
    );

    // Line sync carries no information the controller needs.
    assign unused_hs = hs_i;

    // A config is pending exactly while the request port is closed.
    assign cfg_pending = ~cfg_ready_o;
    assign cfg_accept  = cfg_valid_i & cfg_ready_o;

    // Bounds computed at a frame boundary already use the config committed there.
    assign skip_rows_nxt = (frame_done && cfg_pending) ? pend_rows : skip_rows;
    assign skip_cols_nxt = (frame_done && cfg_pending) ? pend_cols : skip_cols;

    assign col_bnd = axis_bounds(meas_w, skip_cols_nxt);
    assign row_bnd = axis_bounds(meas_h, skip_rows_nxt);
    assign bnd_fit = col_bnd[2*CNT_BITS] & row_bnd[2*CNT_BITS];

    // Candidate matching and decision of whether this boundary loads new bounds.
    always_comb begin
        match_nxt = '0;
        if (meas_cons && meas_w == cand_w && meas_h == cand_h) begin
            match_nxt = match_cnt + MW'(1);
        end else if (meas_cons) begin
            match_nxt = MW'(1);
        end
        lock_hit    = (match_nxt >= MW'(LOCK_FRAMES));
        stay_locked = meas_cons && (meas_w == frame_w_o) && (meas_h == frame_h_o);
        load_bnd    = frame_done &&
                      (((state == ST_MEASURE) && lock_hit) ||
                       ((state == ST_LOCKED) && stay_locked));
    end

    // Requested skips are captured on the handshake and held until committed.
    always_ff @(posedge clk_i) begin
        if (cfg_accept) begin
            pend_rows <= cfg_skip_rows_i;
            pend_cols <= cfg_skip_cols_i;
        end
    end

    // Lock FSM, config commit at frame boundaries and registered crop window.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            match_cnt   <= '0;
            cand_w      <= '0;
            cand_h      <= '0;
            skip_rows   <= DEF_ROWS;
            skip_cols   <= DEF_COLS;
            cfg_ready_o <= 1'b1;
            locked_o    <= 1'b0;
            crop_en_o   <= 1'b0;
            cfg_err_o   <= 1'b0;
            frame_w_o   <= '0;
            frame_h_o   <= '0;
            col_lo_o    <= '0;
            col_hi_o    <= '0;
            row_lo_o    <= '0;
            row_hi_o    <= '0;
        end else begin
            if (frame_done && cfg_pending) begin
                skip_rows   <= pend_rows;
                skip_cols   <= pend_cols;
                cfg_ready_o <= 1'b1;
            end else if (cfg_accept) begin
                cfg_ready_o <= 1'b0;
            end

            if (frame_done) begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_MEASURE;
                        match_cnt <= '0;
                    end
                    ST_MEASURE: begin
                        match_cnt <= match_nxt;
                        if (meas_cons) begin
                            cand_w <= meas_w;
                            cand_h <= meas_h;
                        end
                        if (lock_hit) begin
                            state     <= ST_LOCKED;
                            locked_o  <= 1'b1;
                            frame_w_o <= meas_w;
                            frame_h_o <= meas_h;
                        end
                    end
                    ST_LOCKED: begin
                        if (!stay_locked) begin
                            state     <= ST_MEASURE;
                            locked_o  <= 1'b0;
                            crop_en_o <= 1'b0;
                            match_cnt <= match_nxt;
                            if (meas_cons) begin
                                cand_w <= meas_w;
                                cand_h <= meas_h;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (load_bnd) begin
                cfg_err_o <= ~bnd_fit;
                crop_en_o <= bnd_fit;
                col_lo_o  <= bnd_fit ? col_bnd[2*CNT_BITS-1:CNT_BITS] : '0;
                col_hi_o  <= bnd_fit ? col_bnd[CNT_BITS-1:0]          : '0;
                row_lo_o  <= bnd_fit ? row_bnd[2*CNT_BITS-1:CNT_BITS] : '0;
                row_hi_o  <= bnd_fit ? row_bnd[CNT_BITS-1:0]          : '0;
            end
        end
    end

endmodule
